// File: rtl/sec_cnt_decoder_pkg.sv
// Shared definitions for the seconds-of-day decoder and the alarm encoder.
//   state_e     : decoder FSM states, one digit weight per D_* state
//   W_*         : seconds weight of each time digit
//   MAX_SEC_DEF : largest legal seconds count (23:59:59)
package sec_cnt_decoder_pkg;

  localparam int unsigned CNT_W_DEF   = 17;
  localparam int unsigned MAX_SEC_DEF = 86399;

  localparam int unsigned W_H1 = 36000;
  localparam int unsigned W_H2 = 3600;
  localparam int unsigned W_M1 = 600;
  localparam int unsigned W_M2 = 60;
  localparam int unsigned W_S1 = 10;

  typedef enum logic [2:0] {
    IDLE,
    D_H1,
    D_H2,
    D_M1,
    D_M2,
    D_S1
  } state_e;

  // Weight subtracted while in a digit state; IDLE has no weight.
  function automatic int unsigned weight_of(input state_e s);
    case (s)
      D_H1:    return W_H1;
      D_H2:    return W_H2;
      D_M1:    return W_M1;
      D_M2:    return W_M2;
      D_S1:    return W_S1;
      default: return 0;
    endcase
  endfunction

  // Digit state that follows s once its digit is resolved.
  function automatic state_e next_digit(input state_e s);
    case (s)
      D_H1:    return D_H2;
      D_H2:    return D_M1;
      D_M1:    return D_M2;
      D_M2:    return D_S1;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sec_cnt_decoder_if.sv
// Request/result bundle of the seconds-of-day decoder.
//   start, sec_cnt         : conversion request (master -> slave)
//   h1,h2,m1,m2,s1,s2      : BCD result digits HH:MM:SS (slave -> master)
//   busy, done, err        : status; done/err are single-cycle pulses
interface sec_cnt_decoder_if #(
  parameter int unsigned CNT_W = 17
);
  logic             start;
  logic [CNT_W-1:0] sec_cnt;
  logic [3:0]       h1, h2, m1, m2, s1, s2;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, sec_cnt,
    input  h1, h2, m1, m2, s1, s2, busy, done, err
  );

  modport slave (
    input  start, sec_cnt,
    output h1, h2, m1, m2, s1, s2, busy, done, err
  );
endinterface

// File: rtl/sec_sub_step.sv
// One compare-subtract step of the digit extraction.
//   state_i : current FSM state, selects the digit weight
//   rem_i   : remaining seconds
//   ge_o    : rem_i >= weight
//   diff_o  : rem_i - weight (only meaningful when ge_o is high)
module sec_sub_step
  import sec_cnt_decoder_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  state_e           state_i,
  input  logic [CNT_W-1:0] rem_i,
  output logic             ge_o,
  output logic [CNT_W-1:0] diff_o
);
  logic [CNT_W-1:0] weight;

  always_comb begin
    weight = CNT_W'(weight_of(state_i));
    ge_o   = (rem_i >= weight);
    diff_o = rem_i - weight;
  end
endmodule

// File: rtl/sec_cnt_decoder.sv
// Sequential decoder from a seconds-of-day count to six BCD digits HH:MM:SS.
// Each digit state repeatedly subtracts its weight while the remainder allows,
// so a state lasts (digit+1) cycles. The visible digits update atomically on
// the final edge and hold between conversions.
//   clk_out : clock, all state on posedge
//   rst_n   : asynchronous active-low reset
//   bus     : request/result bundle (slave side)
module sec_cnt_decoder
  import sec_cnt_decoder_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MAX_SEC = MAX_SEC_DEF
) (
  input  logic              clk_out,
  input  logic              rst_n,
  sec_cnt_decoder_if.slave  bus
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SEC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  // Working digits h1,h2,m1,m2,s1 (h1 at index 4); s2 comes from the remainder.
  logic [4:0][3:0]  work_q, work_d;
  // Visible digits h1..s2 (h1 at index 5).
  logic [5:0][3:0]  dig_q, dig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             ge;
  logic [CNT_W-1:0] diff;

  sec_sub_step #(.CNT_W(CNT_W)) u_step (
    .state_i (state_q),
    .rem_i   (rem_q),
    .ge_o    (ge),
    .diff_o  (diff)
  );

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      work_q  <= '0;
      dig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      dig_q   <= dig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    work_d  = work_q;
    dig_d   = dig_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (state_q == IDLE) begin
      if (bus.start) begin
        if (bus.sec_cnt > MAX_C) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          rem_d   = bus.sec_cnt;
          work_d  = '0;
          busy_d  = 1'b1;
          state_d = D_H1;
        end
      end
    end else if (ge) begin
      rem_d = diff;
      case (state_q)
        D_H1:    work_d[4] = work_q[4] + 4'd1;
        D_H2:    work_d[3] = work_q[3] + 4'd1;
        D_M1:    work_d[2] = work_q[2] + 4'd1;
        D_M2:    work_d[1] = work_q[1] + 4'd1;
        D_S1:    work_d[0] = work_q[0] + 4'd1;
        default: ;
      endcase
    end else if (state_q == D_S1) begin
      // Remainder is below 10 here, so it is the seconds-units digit.
      dig_d   = {work_q, rem_q[3:0]};
      busy_d  = 1'b0;
      done_d  = 1'b1;
      state_d = IDLE;
    end else begin
      state_d = next_digit(state_q);
    end
  end

  assign bus.h1   = dig_q[5];
  assign bus.h2   = dig_q[4];
  assign bus.m1   = dig_q[3];
  assign bus.m2   = dig_q[2];
  assign bus.s1   = dig_q[1];
  assign bus.s2   = dig_q[0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_sec_cnt_decoder.sv
module tb_sec_cnt_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sec_cnt_decoder_if #(.CNT_W(17)) bus ();

  sec_cnt_decoder #(.CNT_W(17), .MAX_SEC(86399)) dut (
    .clk_out (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [23:0] dig;
    logic        err;
    int          exp_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] last_dig = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] to_digits(input int unsigned n);
    int unsigned h, m, s;
    h = n / 3600;
    m = (n % 3600) / 60;
    s = n % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int lat_of(input logic [23:0] d);
    return 5 + int'(d[23:20]) + int'(d[19:16]) + int'(d[15:12]) + int'(d[11:8]) + int'(d[7:4]);
  endfunction

  // Called at a negedge: request a conversion and record the expected outcome.
  task automatic go(input int unsigned n);
    exp_t e;
    bus.start   = 1'b1;
    bus.sec_cnt = 17'(n);
    if (n > 86399) begin
      e.dig     = last_dig;
      e.err     = 1'b1;
      e.exp_cyc = cyc + 1;
    end else begin
      e.dig     = to_digits(n);
      e.err     = 1'b0;
      e.exp_cyc = cyc + 1 + lat_of(e.dig);
      last_dig  = e.dig;
    end
    sb.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Edges from the accept edge to the done edge, and cycles busy was seen high.
  task automatic wait_done(output int lat, output int bcnt);
    int n;
    bit got;
    n = 0;
    bcnt = 0;
    got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (bus.done) got = 1'b1;
      else if (bus.busy) bcnt++;
    end
    if (!got) check("done_timeout", 32'(bus.done), 32'd1);
    lat = n - 1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("digits", 32'({bus.h1, bus.h2, bus.m1, bus.m2, bus.s1, bus.s2}), 32'(e.dig));
        check("err", 32'(bus.err), 32'(e.err));
        check("done_cycle", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  initial begin
    int lat, bcnt;
    bus.start   = 1'b0;
    bus.sec_cnt = '0;
    #12;
    check("rst_digits", 32'({bus.h1, bus.h2, bus.m1, bus.m2, bus.s1, bus.s2}), 32'h0);
    check("rst_status", 32'({bus.busy, bus.done, bus.err}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // count 0: minimum latency
    go(0);
    wait_done(lat, bcnt);
    check("lat_0", 32'(lat), 32'd5);
    check("busy_at_done", 32'(bus.busy), 32'd0);

    // 23:59:59
    go(86399);
    wait_done(lat, bcnt);
    check("lat_86399", 32'(lat), 32'd29);
    check("busy_cycles_86399", 32'(bcnt), 32'd29);

    // 19:59:59 worst case
    go(71999);
    wait_done(lat, bcnt);
    check("lat_71999", 32'(lat), 32'd34);

    // 12:34:56 then out-of-range request
    go(45296);
    wait_done(lat, bcnt);
    go(86400);
    wait_done(lat, bcnt);
    check("lat_err", 32'(lat), 32'd0);
    check("busy_err", 32'(bcnt), 32'd0);
    @(negedge clk);
    check("err_cleared", 32'({bus.done, bus.err}), 32'h0);

    // start while busy is ignored, then back-to-back start in the done cycle
    go(45296);
    @(negedge clk);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.sec_cnt = '0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat, bcnt);
    go(3661);
    wait_done(lat, bcnt);
    check("lat_3661", 32'(lat), 32'd7);

    // reset mid-conversion
    go(86399);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_digits", 32'({bus.h1, bus.h2, bus.m1, bus.m2, bus.s1, bus.s2}), 32'h0);
    check("abort_status", 32'({bus.busy, bus.done, bus.err}), 32'h0);
    sb.delete();
    last_dig = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go(60);
    wait_done(lat, bcnt);
    check("lat_60", 32'(lat), 32'd6);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
